// File: rtl/mem_access_unit_pkg.sv
// Shared defines for the memory access unit: op encodings, FSM states,
// sizing constants and op classification helpers.
package mem_access_unit_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8,
        OP_LD   = 4'd9,
        OP_SD   = 4'd10
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_load(input mem_op_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LD};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    // LD/SD only exist on a 64-bit bus; elsewhere they behave as NONE.
    function automatic logic is_mem(input mem_op_e op, input logic wide);
        return (is_load(op) || is_store(op)) && (wide || !(op inside {OP_LD, OP_SD}));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Execute-side, writeback-side and RAM-side signals of the memory access unit.
// slave: the unit's view; master: the surrounding pipeline / RAM model.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RADDR_WIDTH = 5
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic                   valid_i;
    logic [OP_W-1:0]        mem_op_i;
    logic [ADDR_WIDTH-1:0]  mem_addr_i;
    logic [DATA_WIDTH-1:0]  mem_data_i;
    logic [RADDR_WIDTH-1:0] reg_waddr_i;
    logic                   reg_we_i;
    logic [DATA_WIDTH-1:0]  reg_wdata_i;
    logic                   stall_o;
    logic                   ram_req_o;
    logic                   ram_we_o;
    logic [BE_W-1:0]        ram_be_o;
    logic [ADDR_WIDTH-1:0]  ram_addr_o;
    logic [DATA_WIDTH-1:0]  ram_wdata_o;
    logic [DATA_WIDTH-1:0]  ram_rdata_i;
    logic                   ram_ack_i;
    logic                   valid_o;
    logic [RADDR_WIDTH-1:0] reg_waddr_o;
    logic                   reg_we_o;
    logic [DATA_WIDTH-1:0]  reg_wdata_o;
    logic                   err_o;

    modport slave (
        input  valid_i, mem_op_i, mem_addr_i, mem_data_i,
        input  reg_waddr_i, reg_we_i, reg_wdata_i,
        input  ram_rdata_i, ram_ack_i,
        output stall_o, ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        output valid_o, reg_waddr_o, reg_we_o, reg_wdata_o, err_o
    );

    modport master (
        output valid_i, mem_op_i, mem_addr_i, mem_data_i,
        output reg_waddr_i, reg_we_i, reg_wdata_i,
        output ram_rdata_i, ram_ack_i,
        input  stall_o, ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        input  valid_o, reg_waddr_o, reg_we_o, reg_wdata_o, err_o
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and replicated store data for the request,
// lane extraction plus sign/zero extension for load data, misalignment flag.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned BE_W       = DATA_WIDTH / 8,
    localparam int unsigned OFF_W      = $clog2(BE_W)
) (
    input  mem_op_e               op,
    input  logic [OFF_W-1:0]      off,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [BE_W-1:0]       be,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  misaligned
);

    logic [DATA_WIDTH-1:0] shifted;

    // Select lanes by access size; load data is shifted down to bit 0 first.
    always_comb begin
        shifted    = rd_data >> {off, 3'b000};
        be         = '0;
        wdata      = '0;
        ld_data    = '0;
        misaligned = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                be      = BE_W'(1) << off;
                wdata   = {BE_W{st_data[7:0]}};
                ld_data = (op == OP_LBU) ? DATA_WIDTH'(shifted[7:0])
                                         : DATA_WIDTH'($signed(shifted[7:0]));
            end
            OP_LH, OP_LHU, OP_SH: begin
                be         = BE_W'(2'b11) << off;
                wdata      = {(BE_W/2){st_data[15:0]}};
                ld_data    = (op == OP_LHU) ? DATA_WIDTH'(shifted[15:0])
                                            : DATA_WIDTH'($signed(shifted[15:0]));
                misaligned = off[0];
            end
            OP_LW, OP_SW: begin
                be         = BE_W'(4'hF) << off;
                wdata      = {(BE_W/4){st_data[31:0]}};
                ld_data    = DATA_WIDTH'($signed(shifted[31:0]));
                misaligned = (off[1:0] != 2'b00);
            end
            OP_LD, OP_SD: begin
                be         = '1;
                wdata      = st_data;
                ld_data    = rd_data;
                misaligned = (off != '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access pipeline stage: turns execute-stage load/store ops into RAM
// bus requests and produces the writeback result for mem_wb.
// Optional feature: define MISALIGN_EXC_EN to flag misaligned accesses on err_o;
// otherwise misaligned loads write zero and misaligned stores are dropped.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RADDR_WIDTH    = 5,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_access_unit_if.slave bus
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam logic        WIDE  = (DATA_WIDTH == 64);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    mem_op_e                op_q;
    logic [OFF_W-1:0]       off_q;
    logic [ADDR_WIDTH-1:0]  ram_addr_q;
    logic [BE_W-1:0]        ram_be_q;
    logic [DATA_WIDTH-1:0]  ram_wdata_q;
    logic                   ram_we_q;
    logic [RADDR_WIDTH-1:0] res_waddr_q;
    logic                   res_we_q;
    logic [DATA_WIDTH-1:0]  res_wdata_q;
    logic                   err_q;

    mem_op_e               op_in;
    logic                  mem_in;
    logic                  timeout;
    mem_op_e               la_op;
    logic [OFF_W-1:0]      la_off;
    logic [BE_W-1:0]       la_be;
    logic [DATA_WIDTH-1:0] la_wdata;
    logic [DATA_WIDTH-1:0] la_rdata;
    logic                  la_mis;

    assign op_in   = mem_op_e'(bus.mem_op_i);
    assign mem_in  = is_mem(op_in, WIDE);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // One aligner serves both directions: incoming op while accepting, held op while waiting.
    assign la_op  = (state_q == WAIT) ? op_q  : op_in;
    assign la_off = (state_q == WAIT) ? off_q : bus.mem_addr_i[OFF_W-1:0];

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .op         (la_op),
        .off        (la_off),
        .st_data    (bus.mem_data_i),
        .rd_data    (bus.ram_rdata_i),
        .be         (la_be),
        .wdata      (la_wdata),
        .ld_data    (la_rdata),
        .misaligned (la_mis)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: IDLE and DONE both accept; NONE and misaligned ops bypass WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT: begin
                if (bus.ram_ack_i || timeout) state_d = DONE;
            end
            default: begin
                if (bus.valid_i) state_d = (!mem_in || la_mis) ? DONE : WAIT;
                else             state_d = IDLE;
            end
        endcase
    end

    // Capture request and writeback fields on acceptance; collect load data or timeout in WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            op_q        <= OP_NONE;
            off_q       <= '0;
            ram_addr_q  <= '0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            res_waddr_q <= '0;
            res_we_q    <= 1'b0;
            res_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (bus.ram_ack_i) begin
                        if (is_load(op_q)) res_wdata_q <= la_rdata;
                    end else if (timeout) begin
                        res_we_q <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (bus.valid_i) begin
                        op_q        <= op_in;
                        off_q       <= bus.mem_addr_i[OFF_W-1:0];
                        ram_addr_q  <= bus.mem_addr_i & ~ADDR_WIDTH'(BE_W - 1);
                        ram_be_q    <= la_be;
                        ram_wdata_q <= la_wdata;
                        ram_we_q    <= is_store(op_in);
                        cnt_q       <= '0;
                        res_waddr_q <= bus.reg_waddr_i;
                        err_q       <= 1'b0;
                        if (!mem_in) begin
                            res_we_q    <= bus.reg_we_i;
                            res_wdata_q <= bus.reg_wdata_i;
                        end else begin
                            res_we_q    <= is_load(op_in) & bus.reg_we_i;
                            res_wdata_q <= '0;
`ifdef MISALIGN_EXC_EN
                            if (la_mis) begin
                                res_we_q <= 1'b0;
                                err_q    <= 1'b1;
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

    // Outputs: bus fields only in WAIT, result fields only in DONE, zero elsewhere.
    always_comb begin
        bus.stall_o     = ~rst_i & ((state_q == WAIT) || (state_q != WAIT && bus.valid_i && mem_in));
        bus.ram_req_o   = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_be_o    = '0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        bus.valid_o     = 1'b0;
        bus.reg_waddr_o = '0;
        bus.reg_we_o    = 1'b0;
        bus.reg_wdata_o = '0;
        bus.err_o       = 1'b0;
        case (state_q)
            WAIT: begin
                bus.ram_req_o   = 1'b1;
                bus.ram_we_o    = ram_we_q;
                bus.ram_be_o    = ram_be_q;
                bus.ram_addr_o  = ram_addr_q;
                bus.ram_wdata_o = ram_wdata_q;
            end
            DONE: begin
                bus.valid_o     = 1'b1;
                bus.reg_waddr_o = res_waddr_q;
                bus.reg_we_o    = res_we_q;
                bus.reg_wdata_o = res_wdata_q;
                bus.err_o       = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (32-bit bus, TIMEOUT_CYCLES = 15).
// Expectations for the misaligned case follow MISALIGN_EXC_EN.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Results gathered by run_op.
    int          r_stall, r_valid, r_valid_at, r_err, r_req;
    logic        r_changed, r_we, r_reg_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_reg_wdata;
    logic [4:0]  r_waddr;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5)) bus ();

    mem_access_unit #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .RADDR_WIDTH    (5),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (called just after a rising edge), answer the RAM with ack in
    // the ack_at-th request cycle (0 = never) and record what the unit does.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int ack_at,
                          input logic [31:0] rdata);
        int   waits;
        logic done;
        waits = 0; done = 1'b0;
        r_stall = 0; r_valid = 0; r_valid_at = -1; r_err = 0; r_req = 0;
        r_changed = 1'b0; r_we = 1'b0; r_reg_we = 1'b0; r_be = '0;
        r_addr = '0; r_wdata = '0; r_reg_wdata = '0; r_waddr = '0;
        bus.valid_i     = 1'b1;
        bus.mem_op_i    = op;
        bus.mem_addr_i  = addr;
        bus.mem_data_i  = data;
        bus.reg_waddr_i = 5'd7;
        bus.reg_we_i    = 1'b1;
        bus.reg_wdata_i = 32'h5555_5555;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus.stall_o) r_stall++;
            if (bus.err_o)   r_err++;
            if (bus.ram_req_o) begin
                if (r_req == 0) begin
                    r_be = bus.ram_be_o; r_addr = bus.ram_addr_o;
                    r_wdata = bus.ram_wdata_o; r_we = bus.ram_we_o;
                end else if ({bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o, bus.ram_we_o}
                             !== {r_be, r_addr, r_wdata, r_we}) begin
                    r_changed = 1'b1;
                end
                r_req++;
                waits++;
                bus.ram_ack_i   = (ack_at != 0 && waits == ack_at);
                bus.ram_rdata_i = bus.ram_ack_i ? rdata : 32'h0BAD_0BAD;
            end else begin
                bus.ram_ack_i = 1'b0;
            end
            if (bus.valid_o) begin
                r_valid++;
                r_valid_at  = c;
                r_reg_we    = bus.reg_we_o;
                r_reg_wdata = bus.reg_wdata_o;
                r_waddr     = bus.reg_waddr_o;
            end else if (r_valid != 0) begin
                done = 1'b1;
            end
            tick();
            bus.valid_i   = 1'b0;
            bus.mem_op_i  = 4'(OP_NONE);
            bus.ram_ack_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_i = 1'b0; bus.mem_op_i = '0; bus.mem_addr_i = '0; bus.mem_data_i = '0;
        bus.reg_waddr_i = '0; bus.reg_we_i = 1'b0; bus.reg_wdata_i = '0;
        bus.ram_rdata_i = '0; bus.ram_ack_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_ctrl", {bus.stall_o, bus.ram_req_o, bus.ram_we_o, bus.valid_o, bus.reg_we_o, bus.err_o}, 0);
        chk("reset_data", |{bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o, bus.reg_waddr_o, bus.reg_wdata_o}, 0);

        // LW 0x100, ack in the third WAIT cycle.
        run_op(4'(OP_LW), 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", r_stall, 4);
        chk("lw_valid_pulses", r_valid, 1);
        chk("lw_latency", r_valid_at, 4);
        chk("lw_req_cycles", r_req, 3);
        chk("lw_req_stable", r_changed, 0);
        chk("lw_bus", {r_we, r_be, r_addr}, {1'b0, 4'hF, 32'h100});
        chk("lw_result", {r_reg_we, r_waddr, r_reg_wdata}, {1'b1, 5'd7, 32'hDEAD_BEEF});
        chk("lw_err", r_err, 0);

        // Minimum latency with immediate ack.
        run_op(4'(OP_LW), 32'h104, 32'h0, 1, 32'h1357_9BDF);
        chk("lw_min_latency", r_valid_at, 2);
        chk("lw_min_data", r_reg_wdata, 32'h1357_9BDF);

        // Byte loads from the top lane.
        run_op(4'(OP_LB), 32'h103, 32'h0, 1, 32'h80FF_0000);
        chk("lb_be", r_be, 4'b1000);
        chk("lb_addr", r_addr, 32'h100);
        chk("lb_data", r_reg_wdata, 32'hFFFF_FF80);
        run_op(4'(OP_LBU), 32'h103, 32'h0, 2, 32'h80FF_0000);
        chk("lbu_data", r_reg_wdata, 32'h0000_0080);

        // Half loads from the upper half.
        run_op(4'(OP_LH), 32'h102, 32'h0, 1, 32'hBEEF_1234);
        chk("lh_be", r_be, 4'b1100);
        chk("lh_data", r_reg_wdata, 32'hFFFF_BEEF);
        run_op(4'(OP_LHU), 32'h102, 32'h0, 1, 32'hBEEF_1234);
        chk("lhu_data", r_reg_wdata, 32'h0000_BEEF);

        // Stores: replicated data, lane enables, no register write.
        run_op(4'(OP_SH), 32'h102, 32'h1234_ABCD, 1, 32'h0);
        chk("sh_bus", {r_we, r_be, r_addr, r_wdata}, {1'b1, 4'b1100, 32'h100, 32'hABCD_ABCD});
        chk("sh_reg_we", {r_valid[0], r_reg_we}, 2'b10);
        run_op(4'(OP_SB), 32'h201, 32'h0000_007E, 2, 32'h0);
        chk("sb_bus", {r_we, r_be, r_addr, r_wdata}, {1'b1, 4'b0010, 32'h200, 32'h7E7E_7E7E});
        chk("sb_reg_we", r_reg_we, 0);
        run_op(4'(OP_SW), 32'h104, 32'hCAFE_F00D, 1, 32'h0);
        chk("sw_bus", {r_we, r_be, r_addr, r_wdata}, {1'b1, 4'hF, 32'h104, 32'hCAFE_F00D});

        // NONE passes writeback fields through with one-cycle latency.
        run_op(4'(OP_NONE), 32'h0, 32'h0, 0, 32'h0);
        chk("none_latency", r_valid_at, 1);
        chk("none_nostall", {r_stall, r_req}, 0);
        chk("none_result", {r_reg_we, r_waddr, r_reg_wdata}, {1'b1, 5'd7, 32'h5555_5555});

        // Timeout: no ack at all.
        run_op(4'(OP_LW), 32'h300, 32'h0, 0, 32'h0);
        chk("to_req_cycles", r_req, 15);
        chk("to_err", r_err, 1);
        chk("to_valid", r_valid, 1);
        chk("to_reg_we", r_reg_we, 0);
        chk("to_stall", r_stall, 16);

        // Ack in the fifteenth WAIT cycle wins over the timeout.
        run_op(4'(OP_LW), 32'h300, 32'h0, 15, 32'hA5A5_5A5A);
        chk("ack15_err", r_err, 0);
        chk("ack15_result", {r_reg_we, r_reg_wdata}, {1'b1, 32'hA5A5_5A5A});
        chk("ack15_req", r_req, 15);

        // Misaligned half load.
        run_op(4'(OP_LH), 32'h101, 32'h0, 1, 32'hFFFF_FFFF);
        chk("mis_no_req", r_req, 0);
        chk("mis_valid", r_valid, 1);
`ifdef MISALIGN_EXC_EN
        chk("mis_err", r_err, 1);
        chk("mis_reg_we", r_reg_we, 0);
`else
        chk("mis_err", r_err, 0);
        chk("mis_result", {r_reg_we, r_reg_wdata}, {1'b1, 32'h0});
`endif

        // Back-to-back NONE ops: the second is accepted in the DONE cycle.
        bus.valid_i = 1'b1; bus.mem_op_i = 4'(OP_NONE);
        bus.reg_waddr_i = 5'd3; bus.reg_we_i = 1'b1; bus.reg_wdata_i = 32'h1111_1111;
        tick();
        bus.reg_waddr_i = 5'd4; bus.reg_wdata_i = 32'h2222_2222;
        #1;
        chk("b2b_first", {bus.valid_o, bus.stall_o, bus.reg_waddr_o, bus.reg_wdata_o}, {2'b10, 5'd3, 32'h1111_1111});
        tick();
        bus.valid_i = 1'b0;
        #1;
        chk("b2b_second", {bus.valid_o, bus.reg_waddr_o, bus.reg_wdata_o}, {1'b1, 5'd4, 32'h2222_2222});
        tick();
        #1;
        chk("b2b_idle", bus.valid_o, 0);

        // Reset in the middle of WAIT abandons the access.
        bus.valid_i = 1'b1; bus.mem_op_i = 4'(OP_LW); bus.mem_addr_i = 32'h400;
        tick();
        bus.valid_i = 1'b0;
        tick();
        chk("rstwait_req", bus.ram_req_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstwait_ctrl", {bus.stall_o, bus.ram_req_o, bus.ram_we_o, bus.valid_o, bus.reg_we_o, bus.err_o}, 0);
        chk("rstwait_data", |{bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o, bus.reg_waddr_o, bus.reg_wdata_o}, 0);
        tick();
        run_op(4'(OP_LW), 32'h408, 32'h0, 2, 32'h0F0F_F0F0);
        chk("post_rst_lw", {r_valid[0], r_reg_we, r_reg_wdata, r_addr}, {2'b11, 32'h0F0F_F0F0, 32'h408});
        chk("post_rst_err", r_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_WIDTH, 32, data memory address width.
  DATA_WIDTH, 32, data bus width; legal values are 32 and 64.
  RADDR_WIDTH, 5, register-file address width.
  TIMEOUT_CYCLES, 15, maximum wait for ram_ack_i; range 1..255.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning. Derived width: BE_W = DATA_WIDTH/8.
  clk_i  in  1  clock; all state changes on the rising edge.
  rst_i  in  1  reset, synchronous, active-high.
  valid_i  in  1  execute stage presents an instruction.
  mem_op_i  in  4  LB/LH/LW/LBU/LHU/SB/SH/SW/NONE, plus LD/SD when DATA_WIDTH=64.
  mem_addr_i  in  ADDR_WIDTH  byte address.
  mem_data_i  in  DATA_WIDTH  store data, right-aligned.
  reg_waddr_i / reg_we_i / reg_wdata_i  in  RADDR_WIDTH/1/DATA_WIDTH  writeback fields from execute.
  stall_o  out  1  holds the upstream pipeline.
  ram_req_o  out  1  access request.
  ram_we_o  out  1  1 = write.
  ram_be_o  out  BE_W  byte enables.
  ram_addr_o  out  ADDR_WIDTH  bus address, aligned to the bus width.
  ram_wdata_o  out  DATA_WIDTH  lane-shifted store data.
  ram_rdata_i  in  DATA_WIDTH  read data; valid only with ram_ack_i.
  ram_ack_i  in  1  access complete.
  valid_o  out  1  one-cycle result pulse to mem_wb.
  reg_waddr_o / reg_we_o / reg_wdata_o  out  RADDR_WIDTH/1/DATA_WIDTH  writeback result.
  err_o  out  1  one-cycle pulse on bus timeout or misalignment.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-004 In IDLE with valid_i=1 and mem_op_i=NONE, the block SHALL register the writeback fields and assert valid_o on the next cycle (1-cycle latency), with no stall and no RAM access.
REQ-005 In IDLE with valid_i=1 and a memory op, the block SHALL capture all inputs and go to WAIT; from that edge, ram_req_o SHALL remain 1 with constant address, byte enables and data until ram_ack_i=1.
REQ-006 stall_o SHALL be 1 in WAIT and in the cycle the memory op is accepted (combinational from valid_i and mem_op_i), and 0 in DONE and otherwise.
REQ-007 In WAIT with ram_ack_i=1, the block SHALL: register formatted load data; drop ram_req_o; go to DONE.
REQ-008 DONE SHALL assert valid_o for one cycle and return to IDLE; a new valid_i SHALL be accepted in that same DONE cycle.
REQ-009 Minimum load/store latency SHALL therefore be 2 cycles from acceptance to valid_o (ack in the first WAIT cycle).
REQ-010 Byte enables SHALL select: 1 lane for byte ops, 2 for half, 4 for word, all for LD/SD.
REQ-011 Store data SHALL be replicated into the selected lane(s); no read-modify-write is performed.
REQ-012 Loads SHALL extract the selected lane(s) and sign-extend (LB/LH/LW) or zero-extend (LBU/LHU) to DATA_WIDTH.
REQ-013 Stores SHALL drive reg_we_o=0.
REQ-014 A wait counter SHALL increment each WAIT cycle without ack.
REQ-015 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL drop ram_req_o, pulse err_o, force reg_we_o=0 in DONE, and return to IDLE through DONE.
REQ-016 An ack arriving in the same cycle the counter reaches the limit SHALL take priority over the timeout.

Reset
REQ-017 rst_i=1 at a clock edge SHALL force IDLE, clear the counter, and drive 0 on every output, including mid-WAIT; an in-flight access is abandoned.

Configuration
REQ-018 With MISALIGN_EXC_EN defined, a misaligned access (half at odd address; word at address[1:0]!=0) SHALL skip RAM, go directly to DONE, pulse err_o, and keep reg_we_o=0.
REQ-019 With MISALIGN_EXC_EN undefined, a misaligned load SHALL write zero, and a misaligned store SHALL issue no request and complete in DONE.

Structure
REQ-020 The mem_op encodings, FSM state enumeration and sizing constants SHALL reside in the shared defines package.
REQ-021 Lane steering and extension logic SHALL form one combinational sub-module, mem_lane_align.

Verification
REQ-022 LW at 0x100; ack after 3 wait cycles with rdata 0xDEADBEEF -> stall_o high for 4 cycles, valid_o once, reg_wdata_o=0xDEADBEEF.
REQ-023 LB at 0x103, rdata 0x80FF_0000 -> reg_wdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-024 SH at 0x102, data 0x1234ABCD -> ram_be_o=4'b1100, ram_wdata_o=0xABCDABCD, reg_we_o=0.
REQ-025 No ack for 15 cycles -> err_o pulse, ram_req_o drops, reg_we_o=0; ack on cycle 15 -> normal completion, no err_o.
REQ-026 LH at 0x101 -> with MISALIGN_EXC_EN, err_o and no ram_req_o; without it, reg_wdata_o=0.
REQ-027 rst_i asserted mid-WAIT -> next cycle IDLE, all outputs 0; a following LW completes normally.
